// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_pkg
// Description : Shared encodings for the data-memory responder: access size
//               codes and responder FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_responder_pkg;

  // Access size encodings carried on req_size
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_RSVD = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  // Responder FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lane_align
// Description : Combinational alignment / range check, big-endian byte-lane
//               extraction for loads and byte-enable / data replication for
//               stores. Works on the naturally aligned word holding the
//               access; byteEn[3] is the lowest address (the MSB lane).
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_align
  import dmem_responder_pkg::*;
#(
  parameter int SIZE = 16384
) (
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] memWord,
  output logic        err,
  output logic [31:0] rdata,
  output logic [3:0]  byteEn,
  output logic [31:0] wrWord
);

  localparam int AW = $clog2(SIZE);

  logic       w_inRange;
  logic [4:0] w_byteShift;
  logic [4:0] w_halfShift;

  // No wrap-around: any set bit above the array index is out of range
  assign w_inRange = (addr >> AW) == 32'd0;

  // Big-endian: offset 0 sits in bits 31:24, so the shift is 8*(3-offset)
  assign w_byteShift = {~addr[1:0], 3'b000};
  assign w_halfShift = {~addr[1], 4'b0000};

  // Decode size/offset into read data, write lanes and error
  always_comb begin
    err    = 1'b0;
    rdata  = 32'd0;
    byteEn = 4'b0000;
    wrWord = 32'd0;
    case (size)
      SZ_BYTE: begin
        rdata  = (memWord >> w_byteShift) & 32'h0000_00FF;
        byteEn = 4'b1000 >> addr[1:0];
        wrWord = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        err    = addr[0];
        rdata  = (memWord >> w_halfShift) & 32'h0000_FFFF;
        byteEn = addr[1] ? 4'b0011 : 4'b1100;
        wrWord = {2{wdata[15:0]}};
      end
      SZ_WORD: begin
        err    = (addr[1:0] != 2'b00);
        rdata  = memWord;
        byteEn = 4'b1111;
        wrWord = wdata;
      end
      SZ_RSVD: begin
        err = 1'b1;
      end
      default: begin
        err = 1'b1;
      end
    endcase
    if (!w_inRange) begin
      err = 1'b1;
    end
    // Stores and rejected requests return zero; only good stores write
    if (err || wr) begin
      rdata = 32'd0;
    end
    if (err || !wr) begin
      byteEn = 4'b0000;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Memory-side end of the MEM-stage load/store interface. Accepts
//               one request at a time, waits LATENCY cycles, performs the
//               access on a big-endian byte array and returns a one-cycle
//               response pulse with right-justified, zero-filled read data
//               or an error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int SIZE    = 16384,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int             AW         = $clog2(SIZE);
  localparam logic [3:0]     c_latCount = 4'(LATENCY);
  localparam logic [AW-1:0]  c_wordMask = ~(AW'(3));

  state_t        r_state;
  logic [3:0]    r_count;
  logic          r_wr;
  logic [1:0]    r_size;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [7:0]    r_mem [SIZE];

  logic          w_accept;
  logic          w_access;
  logic          w_curWr;
  logic [1:0]    w_curSize;
  logic [31:0]   w_curAddr;
  logic [31:0]   w_curWdata;
  logic [AW-1:0] w_base;
  logic [31:0]   w_memWord;
  logic          w_err;
  logic [31:0]   w_rdata;
  logic [3:0]    w_byteEn;
  logic [31:0]   w_wrWord;

  assign req_ready = (r_state == S_IDLE) && !rst;
  assign w_accept  = req_valid && req_ready;

  // Access fires on the edge that enters RESP (directly from IDLE when there are no wait states)
  assign w_access = !rst &&
                    (((r_state == S_IDLE) && w_accept && (LATENCY == 0)) ||
                     ((r_state == S_WAIT) && (r_count == 4'd0)));

  // In IDLE the live request is the one being accepted; afterwards use the latched copy
  assign w_curWr    = (r_state == S_IDLE) ? req_wr    : r_wr;
  assign w_curSize  = (r_state == S_IDLE) ? req_size  : r_size;
  assign w_curAddr  = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_curWdata = (r_state == S_IDLE) ? req_wdata : r_wdata;

  assign w_base = w_curAddr[AW-1:0] & c_wordMask;

  // Gather the aligned word, lowest address in the MSB lane
  always_comb begin
    w_memWord = {r_mem[w_base],
                 r_mem[w_base | AW'(1)],
                 r_mem[w_base | AW'(2)],
                 r_mem[w_base | AW'(3)]};
  end

  dmem_lane_align #(
    .SIZE (SIZE)
  ) u_align (
    .wr      (w_curWr),
    .size    (w_curSize),
    .addr    (w_curAddr),
    .wdata   (w_curWdata),
    .memWord (w_memWord),
    .err     (w_err),
    .rdata   (w_rdata),
    .byteEn  (w_byteEn),
    .wrWord  (w_wrWord)
  );

  // Byte array write: only enabled lanes of a good store change
  always_ff @(posedge clk) begin
    if (w_access) begin
      for (int i = 0; i < 4; i++) begin
        if (w_byteEn[3-i]) begin
          r_mem[w_base | AW'(i)] <= w_wrWord[31-8*i -: 8];
        end
      end
    end
  end

  // Request FSM, wait counter and registered response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_count    <= 4'd0;
      r_wr       <= 1'b0;
      r_size     <= SZ_BYTE;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_wr    <= req_wr;
            r_size  <= req_size;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            if (LATENCY == 0) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_count <= c_latCount;
            end
          end
        end
        S_WAIT: begin
          if (r_count == 4'd0) begin
            r_state <= S_RESP;
          end else begin
            r_count <= r_count - 4'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
      if (w_access) begin
        resp_valid <= 1'b1;
        resp_err   <= w_err;
        resp_rdata <= w_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder. A transaction-level
//               model (byte array + pending-request timing) predicts ready,
//               response pulse, data and error every cycle; directed
//               sequences add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int SIZE = 16384;
  localparam int LAT  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b1;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [1:0]  req_size = 2'b11;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  always #5 clk = ~clk;

  dmem_responder #(
    .SIZE    (SIZE),
    .LATENCY (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  int nCmp = 0;
  int nBad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    nCmp++;
    if (act !== want) begin
      nBad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [7:0]  mdl [SIZE];
  int        cyc = 0;
  int        readyFrom = 0;
  bit        pend = 0;
  int        respAt = 0;
  bit        pWr;
  bit [1:0]  pSz;
  bit [31:0] pAddr, pWd;
  bit [31:0] expRd = 0;
  bit        expErr = 0;

  bit dutRdyQ = 0;
  int dutAccCnt = 0, dutAccEdge = 0, dutRespCnt = 0, lastDutResp = -100;

  // Apply the pending request to the model memory from the rules directly
  task automatic modelAccess();
    int n;
    bit e;
    e = (pSz == 2'b10) || (pSz == 2'b01 && pAddr[0]) ||
        (pSz == 2'b11 && pAddr[1:0] != 2'b00) || (pAddr >= 32'(SIZE));
    n = (pSz == 2'b00) ? 1 : (pSz == 2'b01) ? 2 : 4;
    expErr = e;
    expRd  = 32'd0;
    if (!e) begin
      for (int i = 0; i < n; i++) begin
        if (pWr) mdl[int'(pAddr) + i] = pWd[8*(n-1-i) +: 8];
        else     expRd = (expRd << 8) | 32'(mdl[int'(pAddr) + i]);
      end
    end
  endtask

  // Model step at each rising edge: reset, access, accept
  initial forever begin
    @(posedge clk);
    cyc++;
    if (req_valid && dutRdyQ) begin
      dutAccCnt++;
      dutAccEdge = cyc;
    end
    if (rst) begin
      pend = 0;
      readyFrom = cyc;
    end else begin
      if (pend && cyc == respAt) modelAccess();
      if (pend && cyc == respAt + 1) pend = 0;
      if (req_valid && (cyc - 1) >= readyFrom) begin
        pend = 1; pWr = req_wr; pSz = req_size; pAddr = req_addr; pWd = req_wdata;
        respAt = cyc + LAT + 1;
        readyFrom = cyc + LAT + 2;
      end
    end
  end

  // Per-cycle comparison at the falling edge
  initial forever begin
    bit eR, eV;
    @(negedge clk);
    eR = !rst && (cyc >= readyFrom);
    eV = pend && (cyc == respAt);
    dutRdyQ = req_ready;
    if (resp_valid === 1'b1) begin
      dutRespCnt++;
      lastDutResp = cyc;
    end
    chk("req_ready", 32'(req_ready), 32'(eR));
    chk("resp_valid", 32'(resp_valid), 32'(eV));
    if (eV) begin
      chk("resp_rdata", resp_rdata, expRd);
      chk("resp_err", 32'(resp_err), 32'(expErr));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic setReq(input bit wr, input bit [1:0] sz, input bit [31:0] a, input bit [31:0] wd);
    req_wr = wr; req_size = sz; req_addr = a; req_wdata = wd; req_valid = 1'b1;
  endtask

  task automatic waitAccept(output int accEdge);
    int c0;
    c0 = dutAccCnt;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (dutAccCnt != c0) break;
    end
    chk("accept_seen", 32'(dutAccCnt != c0), 32'd1);
    accEdge = dutAccEdge;
  endtask

  task automatic waitResp(output bit [31:0] rd, output bit er, output int at);
    bit got;
    got = 0; rd = 32'd0; er = 1'b0; at = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        rd = resp_rdata; er = resp_err; at = cyc; got = 1;
        break;
      end
    end
    chk("resp_seen", 32'(got), 32'd1);
  endtask

  task automatic doReq(input string name, input bit wr, input bit [1:0] sz, input bit [31:0] a,
                       input bit [31:0] wd, input bit [31:0] wantRd, input bit wantErr);
    int acc, at;
    bit [31:0] rd;
    bit er;
    @(posedge clk); #1;
    setReq(wr, sz, a, wd);
    waitAccept(acc);
    req_valid = 1'b0;
    waitResp(rd, er, at);
    chk({name, "_latency"}, 32'(at - acc), 32'(LAT + 1));
    chk({name, "_rdata"}, rd, wantRd);
    chk({name, "_err"}, 32'(er), 32'(wantErr));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a1, a2, rc, at, r;
    bit [31:0] rd;
    bit er;

    // Reset held two cycles with a request present
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(req_ready), 32'd1);
    chk("no_accept_in_rst", 32'(dutAccCnt), 32'd0);

    // Basic word/half/byte traffic
    doReq("st_w100", 1'b1, 2'b11, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0);
    doReq("ld_w100", 1'b0, 2'b11, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0);
    doReq("ld_b101", 1'b0, 2'b00, 32'h101, 32'h0, 32'h000000AD, 1'b0);
    doReq("ld_h102", 1'b0, 2'b01, 32'h102, 32'h0, 32'h0000BEEF, 1'b0);
    doReq("st_b103", 1'b1, 2'b00, 32'h103, 32'h12345677, 32'h0, 1'b0);
    doReq("ld_w100b", 1'b0, 2'b11, 32'h100, 32'h0, 32'hDEADBE77, 1'b0);

    // Rejected requests leave memory untouched
    doReq("err_h105", 1'b1, 2'b01, 32'h105, 32'hFFFFFFFF, 32'h0, 1'b1);
    doReq("ld_w104", 1'b0, 2'b11, 32'h104, 32'h0, 32'h0, 1'b0);
    doReq("err_w102", 1'b0, 2'b11, 32'h102, 32'h0, 32'h0, 1'b1);
    doReq("err_rsvd", 1'b1, 2'b10, 32'h100, 32'hFFFFFFFF, 32'h0, 1'b1);
    doReq("err_ld4000", 1'b0, 2'b11, 32'h4000, 32'h0, 32'h0, 1'b1);
    doReq("err_st4000", 1'b1, 2'b11, 32'h4000, 32'h11223344, 32'h0, 1'b1);
    doReq("ld_w000", 1'b0, 2'b11, 32'h0, 32'h0, 32'h0, 1'b0);
    doReq("ld_w100c", 1'b0, 2'b11, 32'h100, 32'h0, 32'hDEADBE77, 1'b0);
    doReq("ld_wlast", 1'b0, 2'b11, 32'(SIZE - 4), 32'h0, 32'h0, 1'b0);

    // Request held through WAIT with a changing address
    doReq("st_b108", 1'b1, 2'b00, 32'h108, 32'h000000A5, 32'h0, 1'b0);
    @(posedge clk); #1;
    setReq(1'b0, 2'b11, 32'h104, 32'h0);
    waitAccept(a1);
    req_addr = 32'h108;
    @(negedge clk);
    chk("hold_ready_low", 32'(req_ready), 32'd0);
    waitAccept(a2);
    req_valid = 1'b0;
    chk("hold_accept_after_resp", 32'(a2), 32'(lastDutResp + 2));
    waitResp(rd, er, at);
    chk("hold_rdata", rd, 32'hA5000000);
    chk("hold_latency", 32'(at - a2), 32'(LAT + 1));

    // Reset during WAIT abandons a store
    @(posedge clk); #1;
    setReq(1'b1, 2'b11, 32'h200, 32'hCAFEF00D);
    waitAccept(a1);
    req_valid = 1'b0;
    rc = dutRespCnt;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    chk("rst_wait_no_resp", 32'(dutRespCnt), 32'(rc));
    doReq("ld_w200", 1'b0, 2'b11, 32'h200, 32'h0, 32'h0, 1'b0);

    // Randomized traffic, including changes while busy and reset pulses
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 249) == 0);
      req_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        req_wr    = 1'($urandom_range(0, 1));
        req_size  = 2'($urandom_range(0, 3));
        req_wdata = $urandom;
        r = int'($urandom_range(0, 19));
        if (r == 0)      req_addr = $urandom;
        else if (r == 1) req_addr = 32'(SIZE - 4) + $urandom_range(0, 7);
        else             req_addr = 32'h300 + $urandom_range(0, 31);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
`default_nettype wire
